// File: rtl/keep_one_in_n_ctrl_pkg.sv
// Shared types and defaults for the keep_one_in_n rate controller.
package keep_one_in_n_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [7:0] SR_N_DEFAULT = 8'd130;

endpackage

// File: rtl/keep_one_in_n_ctrl_axis_gate.sv
// AXI-Stream valid/ready gate with a packet-boundary tracker on the upstream side.
module axis_gate #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_open,
  input  logic [WIDTH-1:0] i_up_tdata,
  input  logic             i_up_tlast,
  input  logic             i_up_tvalid,
  output logic             o_up_tready,
  output logic [WIDTH-1:0] o_dn_tdata,
  output logic             o_dn_tlast,
  output logic             o_dn_tvalid,
  input  logic             i_dn_tready,
  output logic             o_in_pkt,
  output logic             o_in_pkt_nx
);

  logic r_in_pkt;
  logic w_hs;
  logic w_in_pkt_nx;

  assign o_dn_tdata  = i_up_tdata;
  assign o_dn_tlast  = i_up_tlast;
  assign o_dn_tvalid = i_up_tvalid & i_open;
  assign o_up_tready = i_dn_tready & i_open;

  // Post-handshake packet state: a beat without tlast opens a packet, tlast closes it.
  always_comb begin
    w_hs        = i_up_tvalid & o_up_tready;
    w_in_pkt_nx = r_in_pkt;
    if (w_hs) begin
      w_in_pkt_nx = ~i_up_tlast;
    end else begin
      w_in_pkt_nx = r_in_pkt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_pkt <= 1'b0;
    end else begin
      r_in_pkt <= w_in_pkt_nx;
    end
  end

  assign o_in_pkt    = r_in_pkt;
  assign o_in_pkt_nx = w_in_pkt_nx;

endmodule

// File: rtl/keep_one_in_n_ctrl.sv
// Rate controller for keep_one_in_n: defers settings-bus rate writes to a packet
// boundary, then closes the stream, resets the decimator and loads the new n.
module keep_one_in_n_ctrl
  import keep_one_in_n_ctrl_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter int         MAX_N       = 65535,
  parameter logic [7:0] SR_N        = SR_N_DEFAULT,
  parameter int         N_INIT      = 1,
  parameter int         HOLD_CYCLES = 2,
  localparam int        NW          = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [NW-1:0]    n,
  output logic             dec_rst,
  output logic             busy,
  output logic [15:0]      upd_cnt
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [NW-1:0]    r_n;
  logic [NW-1:0]    r_pend_n;
  logic             r_pend;
  logic [15:0]      r_upd_cnt;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_dec_rst;

  logic             w_open;
  logic             w_in_pkt;
  logic             w_in_pkt_nx;
  logic             w_wr;
  logic [NW-1:0]    w_set_n;
  logic             w_enter_hold;

  assign w_open = (r_state == RUN) | (r_state == DRAIN);

  axis_gate #(
    .WIDTH (WIDTH)
  ) u_gate (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_open      (w_open),
    .i_up_tdata  (i_tdata),
    .i_up_tlast  (i_tlast),
    .i_up_tvalid (i_tvalid),
    .o_up_tready (i_tready),
    .o_dn_tdata  (o_tdata),
    .o_dn_tlast  (o_tlast),
    .o_dn_tvalid (o_tvalid),
    .i_dn_tready (o_tready),
    .o_in_pkt    (w_in_pkt),
    .o_in_pkt_nx (w_in_pkt_nx)
  );

  // Rate write decode with saturation to MAX_N.
  always_comb begin
    w_wr = set_stb & (set_addr == SR_N);
    if (set_data > 32'(MAX_N)) begin
      w_set_n = NW'(MAX_N);
    end else begin
      w_set_n = set_data[NW-1:0];
    end
  end

  // Next-state logic; DRAIN always holds in_pkt=1, so a falling in_pkt is the tlast handshake.
  always_comb begin
    w_state_nx   = r_state;
    w_enter_hold = 1'b0;
    case (r_state)
      RUN: begin
        if (r_pend) begin
          if (!w_in_pkt_nx) begin
            w_state_nx   = HOLD;
            w_enter_hold = 1'b1;
          end else begin
            w_state_nx = DRAIN;
          end
        end else begin
          w_state_nx = RUN;
        end
      end
      DRAIN: begin
        if (w_in_pkt & ~w_in_pkt_nx) begin
          w_state_nx   = HOLD;
          w_enter_hold = 1'b1;
        end else begin
          w_state_nx = DRAIN;
        end
      end
      HOLD: begin
        if (r_hold_cnt == {HCW{1'b0}}) begin
          w_state_nx = SETTLE;
        end else begin
          w_state_nx = HOLD;
        end
      end
      SETTLE:  w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_n        <= NW'(N_INIT);
      r_pend_n   <= NW'(N_INIT);
      r_pend     <= 1'b0;
      r_upd_cnt  <= 16'd0;
      r_hold_cnt <= {HCW{1'b0}};
      r_dec_rst  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dec_rst <= (w_state_nx == HOLD);
      if (w_wr) begin
        r_pend_n <= w_set_n;
      end
      // A write in the same cycle as HOLD entry stays pending for the next round.
      if (w_wr) begin
        r_pend <= 1'b1;
      end else if (w_enter_hold) begin
        r_pend <= 1'b0;
      end
      if (w_enter_hold) begin
        r_n        <= r_pend_n;
        r_upd_cnt  <= r_upd_cnt + 16'd1;
        r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
      end else if ((r_state == HOLD) && (r_hold_cnt != {HCW{1'b0}})) begin
        r_hold_cnt <= r_hold_cnt - {{(HCW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign n       = r_n;
  assign dec_rst = r_dec_rst;
  assign upd_cnt = r_upd_cnt;
  assign busy    = r_pend | (r_state != RUN);

endmodule
